// File: rtl/saxis_frame_checker.sv
// AXI4-Stream sink for the test-pattern video master: regenerates the expected
// pattern, checks data/TSTRB/TLAST/USER and keeps per-frame status and error counters.
module saxis_frame_checker #(
  parameter int          C_S_AXIS_TDATA_WIDTH = 32,
  parameter int          PIXELS_HORIZONTAL    = 1280,
  parameter int          PIXELS_VERTICAL      = 1024,
  parameter int          READY_MODE           = 0,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESETN,
  input  logic                                S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_USER,
  output logic                                S_AXIS_TREADY,
  input  logic                                clear_stats,
  output logic                                locked,
  output logic                                frame_done,
  output logic                                err_pulse,
  output logic [15:0]                         frames_ok,
  output logic [15:0]                         data_err_cnt,
  output logic [15:0]                         frame_err_cnt
);

  localparam int WPL = PIXELS_HORIZONTAL / 4;
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(WPL - 1);
  localparam logic [11:0]   LINE_LAST = 12'(PIXELS_VERTICAL - 1);

  typedef enum logic {WAIT_SOF, RECV} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    frame_reg, frame_next;
  logic [11:0]   line_reg, line_next;
  logic [WW-1:0] word_reg, word_next;
  logic          bad_reg, bad_next;
  logic          locked_reg, locked_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          inc_ok, inc_data, inc_frm;

  logic [15:0]   lfsr_reg;
  logic          tready_reg;
  logic          lfsr_fb;
  logic          beat;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign beat    = S_AXIS_TVALID & tready_reg;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      lfsr_reg   <= LFSR_SEED;
      tready_reg <= 1'b0;
    end else begin
      lfsr_reg   <= {lfsr_reg[14:0], lfsr_fb};
      tready_reg <= (READY_MODE == 0) ? 1'b1 : (lfsr_reg[0] | lfsr_reg[1]);
    end
  end

  logic [31:0]   expected;
  logic          at_sof, at_eol, strb_bad, data_err, framing_err;
  logic [3:0]    base_frame;
  logic [11:0]   base_line;
  logic [WW-1:0] base_word;
  logic          base_bad;

  always_comb begin
    state_next  = state_reg;
    frame_next  = frame_reg;
    line_next   = line_reg;
    word_next   = word_reg;
    bad_next    = bad_reg;
    locked_next = locked_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    inc_ok      = 1'b0;
    inc_data    = 1'b0;
    inc_frm     = 1'b0;

    expected    = {frame_reg, line_reg, 16'h0} + 32'(word_reg);
    at_sof      = (line_reg == 12'd0) && (word_reg == '0);
    at_eol      = (word_reg == WORD_LAST);
    strb_bad    = (S_AXIS_TSTRB != '1);
    data_err    = (state_reg == RECV) ? ((S_AXIS_TDATA != expected) | strb_bad) : strb_bad;
    framing_err = (state_reg == RECV) &&
                  ((S_AXIS_TLAST != at_eol) || (S_AXIS_USER != at_sof) ||
                   ((S_AXIS_TDATA[27:0] == 28'd0) && !S_AXIS_USER));

    // A SOF accepted while hunting advances from position (0,0) of the captured frame.
    base_frame  = (state_reg == WAIT_SOF) ? S_AXIS_TDATA[31:28] : frame_reg;
    base_line   = (state_reg == WAIT_SOF) ? 12'd0 : line_reg;
    base_word   = (state_reg == WAIT_SOF) ? '0 : word_reg;
    base_bad    = (state_reg == WAIT_SOF || at_sof) ? 1'b0 : bad_reg;

    if (beat) begin
      if (framing_err) begin
        state_next  = WAIT_SOF;
        locked_next = 1'b0;
        err_next    = 1'b1;
        inc_frm     = 1'b1;
        inc_data    = data_err;
      end else if (state_reg == RECV || S_AXIS_USER) begin
        state_next  = RECV;
        locked_next = 1'b1;
        err_next    = data_err;
        inc_data    = data_err;
        bad_next    = base_bad | data_err;
        frame_next  = base_frame;
        line_next   = base_line;
        // In RECV TLAST already matches the word position, so it also drives the wrap.
        if (S_AXIS_TLAST) begin
          word_next = '0;
          if (base_line == LINE_LAST) begin
            line_next  = 12'd0;
            frame_next = base_frame + 4'd1;
            done_next  = 1'b1;
            inc_ok     = !(base_bad | data_err);
          end else begin
            line_next = base_line + 12'd1;
          end
        end else begin
          word_next = base_word + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_reg  <= WAIT_SOF;
      frame_reg  <= 4'd0;
      line_reg   <= 12'd0;
      word_reg   <= '0;
      bad_reg    <= 1'b0;
      locked_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_reg  <= frame_next;
      line_reg   <= line_next;
      word_reg   <= word_next;
      bad_reg    <= bad_next;
      locked_reg <= locked_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  logic [2:0] inc_vec;
  assign inc_vec = {inc_frm, inc_data, inc_ok};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
        cnt_reg <= 16'd0;
      end else if (clear_stats) begin
        cnt_reg <= 16'd0;
      end else if (inc_vec[gi] && cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign S_AXIS_TREADY = tready_reg;
  assign locked        = locked_reg;
  assign frame_done    = done_reg;
  assign err_pulse     = err_reg;
  assign frames_ok     = g_cnt[0].cnt_reg;
  assign data_err_cnt  = g_cnt[1].cnt_reg;
  assign frame_err_cnt = g_cnt[2].cnt_reg;

endmodule
